lab4_branch_branch_hybrid: RTL and testbench
============================================

# lab4_branch_branch_hybrid

Parametrised successor to the fixed gshare predictor. The block provides runtime-selectable bimodal, gshare or tournament direction prediction with configurable table depth, history length and counter width. A power-on init sweep clears the tables one entry per cycle, and built-in update/mispredict statistics counters replace testbench-side bookkeeping. It sits beside the fetch stage: the prediction read is combinational on `pred_pc`, and the resolved-branch update comes from execute.

## Interface
- `PHT_ENTRIES`, 16: entries per table; power of two, ≥ 4.
- `HIST_BITS`, 4: global history length; 1 ≤ HIST_BITS ≤ log2(PHT_ENTRIES).
- `CTR_BITS`, 2: saturating counter width, ≥ 2.
- `CNT_BITS`, 16: statistics counter width.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mode` in 2: 0 = bimodal, 1 = gshare, 2 and 3 = tournament.
- `pred_pc` in 32: fetch PC to predict.
- `pred_taken` out 1: prediction for `pred_pc`.
- `upd_en` in 1: resolved branch valid this cycle.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: resolved direction.
- `init_busy` out 1: init sweep in progress.
- `upd_count` out CNT_BITS: accepted updates.
- `miss_count` out CNT_BITS: accepted updates that mispredicted.

## Operation
- **IDX:** IDX = log2(PHT_ENTRIES).
- **Bimodal index:** bidx = pc[IDX+1:2].
- **Gshare index:** gidx = pc[IDX+1:2] XOR zero-extended GHR[HIST_BITS-1:0].
- **Tables:** all three tables are held in flops.
  - BPHT: bimodal counters, CTR_BITS wide, indexed by bidx.
  - GPHT: gshare counters, CTR_BITS wide, indexed by gidx.
  - CHT: 2-bit chooser, indexed by bidx.
- **Counter init value:** weakly-not-taken, 2^(CTR_BITS-1)-1. A counter predicts taken when its MSB is 1.
- **Chooser:** init value 01. A chooser MSB of 1 selects gshare.
- **pred_taken by mode:**
  - Mode 0: BPHT[bidx] MSB.
  - Mode 1: GPHT[gidx] MSB.
  - Mode 2/3: the component selected by CHT[bidx].
- **Update, when upd_en and READY:**
  - Indices are recomputed from `upd_pc` and the current GHR.
  - BPHT and GPHT saturate toward `upd_taken`.
  - CHT moves toward gshare (+1, saturating at 11) only when the components disagree and gshare was correct. It moves toward bimodal (−1, saturating at 00) when they disagree and bimodal was correct. Otherwise CHT is unchanged.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}; when HIST_BITS = 1, GHR <= upd_taken.
  - upd_count increments.
  - miss_count increments when the mode-selected prediction for `upd_pc` ≠ `upd_taken`.
  - All tables train regardless of `mode`, so a mode change takes effect on the next cycle with no flush.
- **Statistics:** both counters wrap modulo 2^CNT_BITS.
- **FSM states:**
  - INIT: writes init values to BPHT, GPHT and CHT at entry `init_idx`, then `init_idx`++. Moves to READY after writing entry PHT_ENTRIES-1.
  - READY: normal operation; exits only on reset.
- **During INIT:**
  - `pred_taken` = 0.
  - `upd_en` is ignored: no table, GHR or statistics change.

## Timing
- **While `reset` is high (sampled at the edge):**
  - state <= INIT, init_idx <= 0, GHR <= 0.
  - upd_count and miss_count <= 0.
  - Outputs: init_busy = 1, pred_taken = 0, counts = 0.
- **Sweep:** the first edge after reset deasserts writes entry 0. `init_busy` stays high for exactly PHT_ENTRIES cycles after deassertion. It falls in the cycle after entry PHT_ENTRIES-1 is written.
- **Prediction path:** `pred_taken` is combinational from `pred_pc`, `mode`, current tables and GHR. Latency is 0 cycles.
- **Update path:** an update is written at the edge and is visible to predictions from the next cycle.
- **Same-cycle predict/update to the same entry:** `pred_taken` reflects the pre-update value.
- **Reset mid-sweep or mid-operation:** restarts the full sweep and clears GHR and statistics.
- **PC bits:** bits [1:0] and bits above IDX+1 never affect indexing.

## Test plan
- **Init sweep:** default params, reset 2 cycles, then `upd_en` = 1 throughout the sweep. Required: init_busy high exactly 16 cycles, pred_taken = 0, upd_count = miss_count = 0 at sweep end.
- **Bimodal, always taken:** mode 0, pc 0x4, 10 taken updates, pred_pc = upd_pc. Required: first prediction 0, then 1; upd_count = 10, miss_count = 1.
- **Alternating, gshare vs bimodal:** pc 0x10 alternating T/N, 20 updates per run.
  - Mode 1: the last 8 predictions are all correct.
  - Mode 0: miss_count ≥ 9.
- **Tournament, alternating then mode switch:** mode 2, same alternating pattern, 40 updates. Required: the last 8 predictions are correct, because the chooser migrates to gshare. Then switch to mode 0 with no reset; the next prediction is from BPHT.
- **Same-cycle collision:** pc 0x8 counter at 01, `upd_en` with taken, and pred_pc = 0x8 in the same cycle. Required: pred_taken = 0 that cycle and 1 the next.
- **Reset mid-sweep:** reset after 5 sweep cycles. Required: init_busy high 16 further cycles and counts 0.
- **Saturation, CTR_BITS = 3:** 8 taken then 1 not-taken on pc 0x4. Required: prediction is still taken.

Source files
------------

// File: rtl/lab4_branch_branch_hybrid.sv
`default_nettype none
// ============================================================================
// Module   : lab4_branch_branch_hybrid
// Purpose  : Runtime-selectable bimodal / gshare / tournament branch direction
//            predictor. All three tables live in flops, and a power-on sweep
//            writes one entry per cycle. Update and mispredict statistics
//            counters are built in.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            mode             - 0 bimodal, 1 gshare, 2/3 tournament
//            pred_pc          - fetch PC, combinational lookup
//            pred_taken       - predicted direction for pred_pc
//            upd_en/upd_pc/upd_taken - resolved branch from execute
//            init_busy        - table sweep in progress
//            upd_count/miss_count - accepted updates / mispredicted updates
// Revision : 1.0 - initial release
// ============================================================================
module lab4_branch_branch_hybrid #(
    parameter int PHT_ENTRIES = 16,
    parameter int HIST_BITS   = 4,
    parameter int CTR_BITS    = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    input  logic                upd_en,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    output logic                init_busy,
    output logic [CNT_BITS-1:0] upd_count,
    output logic [CNT_BITS-1:0] miss_count
);

    localparam int c_IDX = $clog2(PHT_ENTRIES);

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    // Weakly-not-taken: MSB clear, every lower bit set.
    localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;
    localparam logic [1:0]          c_CHT_INIT = 2'b01;
    localparam logic [c_IDX-1:0]    c_LAST_IDX = c_IDX'(PHT_ENTRIES - 1);

    logic [0:0]          r_state;
    logic [c_IDX-1:0]    r_init_idx;
    logic [HIST_BITS-1:0] r_ghr;
    logic [CNT_BITS-1:0] r_upd_count;
    logic [CNT_BITS-1:0] r_miss_count;

    logic [CTR_BITS-1:0] r_bpht [PHT_ENTRIES];
    logic [CTR_BITS-1:0] r_gpht [PHT_ENTRIES];
    logic [1:0]          r_cht  [PHT_ENTRIES];

    logic [c_IDX-1:0]    w_pred_bidx;
    logic [c_IDX-1:0]    w_pred_gidx;
    logic [c_IDX-1:0]    w_upd_bidx;
    logic [c_IDX-1:0]    w_upd_gidx;
    logic                w_pred_b;
    logic                w_pred_g;
    logic                w_pred_c;
    logic                w_upd_b;
    logic                w_upd_g;
    logic                w_upd_c;
    logic                w_upd_sel;
    logic [HIST_BITS-1:0] w_ghr_next;
    logic                w_unused_pc;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [CTR_BITS-1:0] f_sat(input logic [CTR_BITS-1:0] v,
                                                  input logic up);
        if (up) begin
            return (v == c_CTR_MAX) ? v : v + CTR_BITS'(1);
        end
        return (v == '0) ? v : v - CTR_BITS'(1);
    endfunction

    function automatic logic f_select(input logic [1:0] md, input logic b,
                                      input logic g, input logic ch);
        case (md)
            2'd0:    return b;
            2'd1:    return g;
            default: return ch ? g : b;
        endcase
    endfunction

    // Chooser only learns when the components disagree; exactly one of them
    // is then right, and the chooser steps toward it.
    function automatic logic [1:0] f_cht(input logic [1:0] ch, input logic b,
                                         input logic g, input logic t);
        if (b != g) begin
            if (g == t) begin
                return (ch == 2'b11) ? ch : ch + 2'b01;
            end
            return (ch == 2'b00) ? ch : ch - 2'b01;
        end
        return ch;
    endfunction

    // ------------------------------------------------------------------------
    // Indexing: word-aligned PC bits, gshare folds in the zero-extended GHR
    // ------------------------------------------------------------------------
    assign w_pred_bidx = pred_pc[c_IDX+1:2];
    assign w_pred_gidx = w_pred_bidx ^ c_IDX'(r_ghr);
    assign w_upd_bidx  = upd_pc[c_IDX+1:2];
    assign w_upd_gidx  = w_upd_bidx ^ c_IDX'(r_ghr);

    // PC bits outside the index field never influence the predictor.
    assign w_unused_pc = ^{pred_pc[31:c_IDX+2], pred_pc[1:0],
                           upd_pc[31:c_IDX+2],  upd_pc[1:0]};

    assign w_pred_b = r_bpht[w_pred_bidx][CTR_BITS-1];
    assign w_pred_g = r_gpht[w_pred_gidx][CTR_BITS-1];
    assign w_pred_c = r_cht[w_pred_bidx][1];

    assign w_upd_b   = r_bpht[w_upd_bidx][CTR_BITS-1];
    assign w_upd_g   = r_gpht[w_upd_gidx][CTR_BITS-1];
    assign w_upd_c   = r_cht[w_upd_bidx][1];
    assign w_upd_sel = f_select(mode, w_upd_b, w_upd_g, w_upd_c);

    generate
        if (HIST_BITS == 1) begin : g_ghr_single
            assign w_ghr_next = upd_taken;
        end else begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    // Reads see pre-update table contents, so a same-cycle update to the
    // looked-up entry is only visible from the following cycle.
    always_comb begin
        pred_taken = 1'b0;
        if (r_state == c_ST_READY) begin
            pred_taken = f_select(mode, w_pred_b, w_pred_g, w_pred_c);
        end
    end

    assign init_busy  = (r_state == c_ST_INIT);
    assign upd_count  = r_upd_count;
    assign miss_count = r_miss_count;

    // ------------------------------------------------------------------------
    // Control FSM, table sweep and training
    // ------------------------------------------------------------------------
    // The tables themselves are not reset: the sweep that follows every reset
    // rewrites them, and predictions are forced low until it completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_INIT;
            r_init_idx   <= '0;
            r_ghr        <= '0;
            r_upd_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_bpht[r_init_idx] <= c_CTR_INIT;
                    r_gpht[r_init_idx] <= c_CTR_INIT;
                    r_cht[r_init_idx]  <= c_CHT_INIT;
                    r_init_idx         <= r_init_idx + c_IDX'(1);
                    if (r_init_idx == c_LAST_IDX) begin
                        r_state <= c_ST_READY;
                    end
                end
                c_ST_READY: begin
                    if (upd_en) begin
                        // All tables train regardless of mode so that a
                        // mode switch needs no warm-up or flush.
                        r_bpht[w_upd_bidx] <= f_sat(r_bpht[w_upd_bidx], upd_taken);
                        r_gpht[w_upd_gidx] <= f_sat(r_gpht[w_upd_gidx], upd_taken);
                        r_cht[w_upd_bidx]  <= f_cht(r_cht[w_upd_bidx], w_upd_b,
                                                    w_upd_g, upd_taken);
                        r_ghr              <= w_ghr_next;
                        r_upd_count        <= r_upd_count + CNT_BITS'(1);
                        if (w_upd_sel != upd_taken) begin
                            r_miss_count <= r_miss_count + CNT_BITS'(1);
                        end
                    end
                end
                default: r_state <= c_ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab4_branch_branch_hybrid.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab4_branch_branch_hybrid
// Purpose  : Self-checking bench for lab4_branch_branch_hybrid. A table-level
//            behavioural model is compared against the default-parameter DUT
//            every cycle; directed scenarios add literal expectations. A
//            second instance with 3-bit counters covers saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab4_branch_branch_hybrid;

    localparam int N    = 16;
    localparam int H    = 4;
    localparam int CB   = 2;
    localparam int HALF = 1 << (CB - 1);
    localparam int CMAX = (1 << CB) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [31:0] pred_pc = 32'h0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic        pred_taken;
    logic        init_busy;
    logic [15:0] upd_count;
    logic [15:0] miss_count;

    logic        reset3 = 1'b1;
    logic        upd_en3 = 1'b0;
    logic        pred_taken3;
    logic        init_busy3;
    logic [15:0] upd_count3;
    logic [15:0] miss_count3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lab4_branch_branch_hybrid #(
        .PHT_ENTRIES(N), .HIST_BITS(H), .CTR_BITS(CB), .CNT_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .init_busy(init_busy),
        .upd_count(upd_count), .miss_count(miss_count)
    );

    lab4_branch_branch_hybrid #(
        .PHT_ENTRIES(16), .HIST_BITS(4), .CTR_BITS(3), .CNT_BITS(16)
    ) dut3 (
        .clk(clk), .reset(reset3), .mode(mode), .pred_pc(pred_pc),
        .pred_taken(pred_taken3), .upd_en(upd_en3), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .init_busy(init_busy3),
        .upd_count(upd_count3), .miss_count(miss_count3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: counters as integers, sweep as a count of entries left
    // ------------------------------------------------------------------------
    int mb [N];
    int mg [N];
    int mc [N];
    int mghr = 0;
    int msweep = 0;
    int muc = 0;
    int mmc = 0;
    bit mvalid = 1'b0;

    function automatic int m_pred(input logic [31:0] pc, input logic [1:0] md);
        int  bi;
        int  gi;
        bit  bp;
        bit  gp;
        if (msweep > 0) return 0;
        bi = int'(pc >> 2) % N;
        gi = bi ^ mghr;
        bp = mb[bi] >= HALF;
        gp = mg[gi] >= HALF;
        if (md == 2'd0) return int'(bp);
        if (md == 2'd1) return int'(gp);
        return (mc[bi] >= 2) ? int'(gp) : int'(bp);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            msweep = N;
            mghr   = 0;
            muc    = 0;
            mmc    = 0;
            mvalid = 1'b1;
        end else if (msweep > 0) begin
            mb[N - msweep] = HALF - 1;
            mg[N - msweep] = HALF - 1;
            mc[N - msweep] = 1;
            msweep--;
        end else if (upd_en) begin
            int bi;
            int gi;
            bit bp;
            bit gp;
            bit sel;
            bi  = int'(upd_pc >> 2) % N;
            gi  = bi ^ mghr;
            bp  = mb[bi] >= HALF;
            gp  = mg[gi] >= HALF;
            sel = (mode == 2'd0) ? bp : (mode == 2'd1) ? gp : ((mc[bi] >= 2) ? gp : bp);
            if (sel != upd_taken) mmc = (mmc + 1) & 16'hFFFF;
            muc = (muc + 1) & 16'hFFFF;
            if (bp != gp) begin
                if (gp == upd_taken) mc[bi] = (mc[bi] < 3) ? mc[bi] + 1 : 3;
                else                 mc[bi] = (mc[bi] > 0) ? mc[bi] - 1 : 0;
            end
            if (upd_taken) begin
                mb[bi] = (mb[bi] < CMAX) ? mb[bi] + 1 : CMAX;
                mg[gi] = (mg[gi] < CMAX) ? mg[gi] + 1 : CMAX;
            end else begin
                mb[bi] = (mb[bi] > 0) ? mb[bi] - 1 : 0;
                mg[gi] = (mg[gi] > 0) ? mg[gi] - 1 : 0;
            end
            mghr = ((mghr << 1) | int'(upd_taken)) & ((1 << H) - 1);
        end
    end

    always @(negedge clk) begin
        #3;
        if (mvalid) begin
            check("m_pred", pred_taken, m_pred(pred_pc, mode));
            check("m_busy", init_busy, msweep > 0);
            check("m_upd",  upd_count, muc);
            check("m_miss", miss_count, mmc);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (entered and left at a falling edge)
    // ------------------------------------------------------------------------
    task automatic do_upd(input logic [31:0] pc, input bit t, output bit p);
        pred_pc   = pc;
        upd_pc    = pc;
        upd_taken = t;
        upd_en    = 1'b1;
        #1;
        p = pred_taken;
        @(negedge clk);
        upd_en = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy) break;
            n++;
            check("sweep_pred0", pred_taken, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p;
        bit pv [10];
        int n;
        int ok;
        int m0;

        // Init sweep with upd_en held high throughout.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mode = 2'd0; upd_en = 1'b1; upd_pc = 32'h4; pred_pc = 32'h4; upd_taken = 1'b1;
        count_busy(n);
        upd_en = 1'b0;
        check("sweep_len", n, 16);
        check("sweep_upd", upd_count, 0);
        check("sweep_miss", miss_count, 0);

        // Bimodal, always taken on pc 0x4.
        mode = 2'd0;
        for (int i = 0; i < 10; i++) begin
            do_upd(32'h4, 1'b1, p);
            pv[i] = p;
        end
        check("bim_first", pv[0], 1'b0);
        check("bim_second", pv[1], 1'b1);
        check("bim_last", pv[9], 1'b1);
        check("bim_upd", upd_count, 10);
        check("bim_miss", miss_count, 1);

        // Alternating on pc 0x10: gshare learns it.
        mode = 2'd1; ok = 0;
        for (int i = 0; i < 20; i++) begin
            do_upd(32'h10, (i % 2) == 0, p);
            if (i >= 12 && p == ((i % 2) == 0)) ok++;
        end
        check("gsh_last8", ok, 8);

        // Same pattern in bimodal: it keeps missing.
        mode = 2'd0; m0 = int'(miss_count);
        for (int i = 0; i < 20; i++) do_upd(32'h10, (i % 2) == 0, p);
        check("bim_alt_miss_ge9", (int'(miss_count) - m0) >= 9, 1'b1);

        // Tournament, then switch to bimodal with no reset.
        mode = 2'd2; ok = 0;
        for (int i = 0; i < 40; i++) begin
            do_upd(32'h10, (i % 2) == 0, p);
            if (i >= 32 && p == ((i % 2) == 0)) ok++;
        end
        check("tour_last8", ok, 8);
        pred_pc = 32'h10;
        #1 check("tour_next", pred_taken, 1'b1);
        mode = 2'd0;
        #1 check("mode0_bpht", pred_taken, 1'b0);
        @(negedge clk);

        // Same-cycle predict/update collision on pc 0x8 (counter at 01).
        pred_pc = 32'h8; upd_pc = 32'h8; upd_taken = 1'b1; upd_en = 1'b1;
        #1 check("coll_same", pred_taken, 1'b0);
        @(negedge clk);
        upd_en = 1'b0;
        #1 check("coll_next", pred_taken, 1'b1);
        @(negedge clk);

        // Reset mid-sweep, with updates offered during the sweep.
        reset = 1'b1; upd_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy5", init_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_busy(n);
        upd_en = 1'b0;
        check("mid_len", n, 16);
        check("mid_upd", upd_count, 0);
        check("mid_miss", miss_count, 0);

        // Saturation with 3-bit counters.
        reset3 = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy3) break;
            n++;
            @(negedge clk);
        end
        check("sat_sweep", n, 16);
        for (int i = 0; i < 9; i++) begin
            pred_pc = 32'h4; upd_pc = 32'h4; upd_taken = (i < 8); upd_en3 = 1'b1;
            #1;
            if (i == 0) check("sat_first", pred_taken3, 1'b0);
            if (i == 8) check("sat_before_n", pred_taken3, 1'b1);
            @(negedge clk);
        end
        upd_en3 = 1'b0;
        #1 check("sat_after_n", pred_taken3, 1'b1);
        check("sat_upd", upd_count3, 9);
        check("sat_miss", miss_count3, 2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
